// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Sequencing controller for the 5-stage PC/nPC -> IF/ID -> ID/EX -> EX/MEM ->
// MEM/WB datapath. Handles the following:
//   * Load-use hazards: the front end (PC/nPC and IF/ID) is held and NOP
//     control words are injected for LOAD_STALLS cycles.
//   * Forwarding selects for both EX operands.
//   * Pipeline freeze: every stage is frozen while data memory is busy.
//   * Stall counter: a saturating count of injected hazard bubbles.
//
// Parameters
//   RA_W         register-address width
//   LOAD_STALLS  bubbles per load-use hazard (1..3)
//   CNT_W        stall statistics counter width
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   id_rs/id_rt, id_use_*      source registers of the instruction in ID
//   ex_rd, ex_rf_en, ex_load   destination info of the instruction in EX
//   mem_rd, mem_rf_en          destination info of the instruction in MEM
//   wb_rd, wb_rf_en            destination info of the instruction in WB
//   mem_busy                   data memory not ready (freeze request)
//   clr_stats                  clear stall_cnt
//   pc_ld, ifid_ld, stage_ld   register load enables
//   nop_sel                    1 = inject the all-zero control word
//   fwd_a, fwd_b               EX operand source: 00 RF, 01 EX/MEM, 10 MEM/WB
//   stall_cnt                  saturating count of hazard bubbles
// -----------------------------------------------------------------------------
module hazard_sequencer #(
  parameter int RA_W        = 5,
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_rf_en,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_rf_en,
  input  logic             mem_busy,
  input  logic             clr_stats,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             stage_ld,
  output logic             nop_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } state_t;

  // The hazard cycle itself is the first bubble.
  // The counter holds the bubbles that are still to come.
  localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_STALLS - 1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff_state;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RA_W-1:0]  ex_rs_q, ex_rs_d;
  logic [RA_W-1:0]  ex_rt_q, ex_rt_d;
  logic             lu_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Nearest producer wins. Register 0 is hardwired, so it is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic [RA_W-1:0] m_rd,
    input logic            m_en,
    input logic [RA_W-1:0] w_rd,
    input logic            w_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (m_en && (m_rd == src))      sel = 2'b01;
      else if (w_en && (w_rd == src)) sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    lu_hit = ex_load & ex_rf_en & (ex_rd != '0) &
             ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  end

  // While frozen, the FSM behaves as the state it was frozen in.
  assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    bcnt_d   = bcnt_q;
    pc_ld    = 1'b0;
    ifid_ld  = 1'b0;
    stage_ld = 1'b0;
    nop_sel  = 1'b1;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;

    if (reset) begin
      fwd_a = fwd_sel(ex_rs_q, mem_rd, mem_rf_en, wb_rd, wb_rf_en);
      fwd_b = fwd_sel(ex_rt_q, mem_rd, mem_rf_en, wb_rd, wb_rf_en);

      if (mem_busy) begin
        // Freeze everything. The bubble counter is left untouched so that
        // the stall resumes exactly where it stopped.
        nop_sel = 1'b0;
        state_d = FREEZE;
        ret_d   = eff_state;
      end else begin
        case (eff_state)
          LU_STALL: begin
            stage_ld = 1'b1;
            if (bcnt_q <= 2'd1) begin
              state_d = RUN;
              bcnt_d  = 2'd0;
            end else begin
              state_d = LU_STALL;
              bcnt_d  = bcnt_q - 2'd1;
            end
          end
          default: begin
            if (lu_hit) begin
              stage_ld = 1'b1;
              if (LOAD_STALLS > 1) begin
                state_d = LU_STALL;
                bcnt_d  = BUBBLE_RELOAD;
              end else begin
                state_d = RUN;
              end
            end else begin
              pc_ld    = 1'b1;
              ifid_ld  = 1'b1;
              stage_ld = 1'b1;
              nop_sel  = 1'b0;
              state_d  = RUN;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    ex_rs_d = stage_ld ? id_rs : ex_rs_q;
    ex_rt_d = stage_ld ? id_rt : ex_rt_q;

    if (clr_stats)                 stall_cnt_d = '0;
    else if (nop_sel && !mem_busy) stall_cnt_d = sat_inc(stall_cnt_q);
    else                           stall_cnt_d = stall_cnt_q;
  end

  // ---- state / ID-EX source register boundary ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      bcnt_q      <= 2'd0;
      stall_cnt_q <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      bcnt_q      <= bcnt_d;
      stall_cnt_q <= stall_cnt_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//
// The bench drives two instances from the same stimulus:
//   * u_ls1: LOAD_STALLS=1 and CNT_W=16.
//   * u_ls3: LOAD_STALLS=3 and CNT_W=4.
// A behavioural model tracks a "bubbles still owed" number for each instance.
// A negedge process compares every output against that model. The stimulus
// process also checks hand-computed literal values at the key points.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_rf_en, ex_load;
  logic       mem_rf_en, wb_rf_en, mem_busy, clr_stats;

  logic        pc_o[2], ifid_o[2], stage_o[2], nop_o[2];
  logic [1:0]  fa_o[2], fb_o[2];
  logic [15:0] sc_ls1;
  logic [3:0]  sc_ls3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.RA_W(5), .LOAD_STALLS(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .mem_busy(mem_busy), .clr_stats(clr_stats),
    .pc_ld(pc_o[0]), .ifid_ld(ifid_o[0]), .stage_ld(stage_o[0]), .nop_sel(nop_o[0]),
    .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .stall_cnt(sc_ls1)
  );

  hazard_sequencer #(.RA_W(5), .LOAD_STALLS(3), .CNT_W(4)) u_ls3 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .mem_busy(mem_busy), .clr_stats(clr_stats),
    .pc_ld(pc_o[1]), .ifid_ld(ifid_o[1]), .stage_ld(stage_o[1]), .nop_sel(nop_o[1]),
    .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .stall_cnt(sc_ls3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_ls[2]   = '{1, 3};
  int         m_max[2]  = '{65535, 15};
  int         m_pend[2] = '{0, 0};   // bubbles still owed after the current one
  int         m_sc[2]   = '{0, 0};
  logic [4:0] m_rs[2]   = '{5'd0, 5'd0};
  logic [4:0] m_rt[2]   = '{5'd0, 5'd0};

  function automatic int m_fwd(input logic [4:0] src);
    if (src == 5'd0) return 0;
    if (mem_rf_en && mem_rd == src) return 1;
    if (wb_rf_en && wb_rd == src) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    bit hit;
    int e_pc, e_if, e_st, e_nop, e_fa, e_fb, a_sc;
    hit = ex_load && ex_rf_en && (ex_rd != 5'd0) &&
          ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    for (int k = 0; k < 2; k++) begin
      e_fa = 0; e_fb = 0;
      if (!reset) begin
        e_pc = 0; e_if = 0; e_st = 0; e_nop = 1;
      end else begin
        e_fa = m_fwd(m_rs[k]);
        e_fb = m_fwd(m_rt[k]);
        if (mem_busy) begin
          e_pc = 0; e_if = 0; e_st = 0; e_nop = 0;
        end else if (m_pend[k] > 0 || hit) begin
          e_pc = 0; e_if = 0; e_st = 1; e_nop = 1;
        end else begin
          e_pc = 1; e_if = 1; e_st = 1; e_nop = 0;
        end
      end
      a_sc = (k == 0) ? int'(sc_ls1) : int'(sc_ls3);
      chk($sformatf("model%0d_pc_ld", k),    int'(pc_o[k]),    e_pc);
      chk($sformatf("model%0d_ifid_ld", k),  int'(ifid_o[k]),  e_if);
      chk($sformatf("model%0d_stage_ld", k), int'(stage_o[k]), e_st);
      chk($sformatf("model%0d_nop_sel", k),  int'(nop_o[k]),   e_nop);
      chk($sformatf("model%0d_fwd_a", k),    int'(fa_o[k]),    e_fa);
      chk($sformatf("model%0d_fwd_b", k),    int'(fb_o[k]),    e_fb);
      chk($sformatf("model%0d_stall_cnt", k), a_sc,            m_sc[k]);
      // advance the model across the coming clock edge
      if (!reset) begin
        m_pend[k] = 0; m_sc[k] = 0; m_rs[k] = 5'd0; m_rt[k] = 5'd0;
      end else begin
        if (!mem_busy) begin
          if (m_pend[k] > 0) m_pend[k]--;
          else if (hit)      m_pend[k] = m_ls[k] - 1;
        end
        if (clr_stats) m_sc[k] = 0;
        else if (e_nop == 1 && !mem_busy && m_sc[k] < m_max[k]) m_sc[k]++;
        if (e_st == 1) begin m_rs[k] = id_rs; m_rt[k] = id_rt; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = 5'd0; ex_rf_en = 1'b0; ex_load = 1'b0;
    mem_rd = 5'd0; mem_rf_en = 1'b0; wb_rd = 5'd0; wb_rf_en = 1'b0;
    mem_busy = 1'b0; clr_stats = 1'b0;
  endtask

  // ID reads r5 as rs while EX holds a load to r5.
  task automatic hazard();
    id_rs = 5'd5; id_use_rs = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
    ex_rd = 5'd5; ex_rf_en = 1'b1; ex_load = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    step(2); #1;
    chk("rst_pc_ld", int'(pc_o[0]), 0);
    chk("rst_nop_sel", int'(nop_o[0]), 1);
    chk("rst_stage_ld", int'(stage_o[1]), 0);
    chk("rst_cnt_ls1", int'(sc_ls1), 0);
    chk("rst_cnt_ls3", int'(sc_ls3), 0);

    reset = 1'b1; #1;
    chk("run_pc_ld", int'(pc_o[0]), 1);
    chk("run_nop_sel", int'(nop_o[0]), 0);

    // Test 1 and test 2: a single load-use hazard.
    step(1); hazard(); #1;
    chk("t1_nop_sel", int'(nop_o[0]), 1);
    chk("t1_pc_ld", int'(pc_o[0]), 0);
    chk("t1_ifid_ld", int'(ifid_o[0]), 0);
    chk("t1_stage_ld", int'(stage_o[0]), 1);
    step(1); idle(); #1;
    chk("t1_resume_pc_ld", int'(pc_o[0]), 1);
    chk("t1_stall_cnt", int'(sc_ls1), 1);
    chk("t2_bubble2_nop", int'(nop_o[1]), 1);
    step(1); #1;
    chk("t2_bubble3_nop", int'(nop_o[1]), 1);
    step(1); #1;
    chk("t2_resume_pc_ld", int'(pc_o[1]), 1);
    chk("t2_stall_cnt", int'(sc_ls3), 3);

    // Test 3: forwarding.
    id_rs = 5'd7; id_rt = 5'd3;
    step(1);
    mem_rd = 5'd7; mem_rf_en = 1'b1; wb_rd = 5'd7; wb_rf_en = 1'b1; #1;
    chk("t3_exmem_wins", int'(fa_o[0]), 1);
    wb_rd = 5'd3; #1;
    chk("t3_b_memwb", int'(fb_o[0]), 2);
    step(1); mem_rf_en = 1'b0; wb_rd = 5'd7; #1;
    chk("t3_a_memwb", int'(fa_o[1]), 2);
    chk("t3_b_rf", int'(fb_o[1]), 0);
    id_rs = 5'd0;
    step(1); mem_rd = 5'd0; mem_rf_en = 1'b1; #1;
    chk("t3_r0_rf", int'(fa_o[0]), 0);
    idle();

    // Test 4: the pipeline freezes during LU_STALL.
    clr_stats = 1'b1; step(1); clr_stats = 1'b0; #1;
    chk("t4_clr_ls3", int'(sc_ls3), 0);
    hazard(); step(1); idle(); mem_busy = 1'b1; #1;
    chk("t4_frz_pc_ld", int'(pc_o[1]), 0);
    chk("t4_frz_stage_ld", int'(stage_o[1]), 0);
    chk("t4_frz_nop_sel", int'(nop_o[1]), 0);
    step(3); #1;
    chk("t4_frz4_ifid_ld", int'(ifid_o[1]), 0);
    step(1); mem_busy = 1'b0; #1;
    chk("t4_resume_nop", int'(nop_o[1]), 1);
    chk("t4_resume_pc_ld", int'(pc_o[1]), 0);
    chk("t4_frz_not_counted", int'(sc_ls3), 1);
    step(1); #1;
    chk("t4_last_bubble_nop", int'(nop_o[1]), 1);
    step(1); #1;
    chk("t4_run_pc_ld", int'(pc_o[1]), 1);
    chk("t4_stall_cnt_ls3", int'(sc_ls3), 3);
    chk("t4_stall_cnt_ls1", int'(sc_ls1), 1);

    // mem_busy takes priority over a load-use hazard.
    hazard(); mem_busy = 1'b1; #1;
    chk("prio_busy_nop", int'(nop_o[0]), 0);
    chk("prio_busy_stage", int'(stage_o[0]), 0);
    step(1); mem_busy = 1'b0; #1;
    chk("prio_hazard_nop", int'(nop_o[0]), 1);
    step(1); idle(); step(3);

    // Test 5: reset during LU_STALL.
    hazard(); step(1); idle(); reset = 1'b0; #1;
    chk("t5_rst_nop", int'(nop_o[1]), 1);
    chk("t5_rst_pc_ld", int'(pc_o[1]), 0);
    step(1); reset = 1'b1; #1;
    chk("t5_after_pc_ld", int'(pc_o[1]), 1);
    chk("t5_after_nop", int'(nop_o[1]), 0);
    chk("t5_after_cnt", int'(sc_ls3), 0);

    // Test 6: stall_cnt saturates at 15 when CNT_W=4.
    for (int i = 0; i < 5; i++) begin
      hazard(); step(1); idle(); step(2);
    end
    chk("t6_cnt15", int'(sc_ls3), 15);
    chk("t6_cnt_ls1", int'(sc_ls1), 5);
    hazard(); step(1); idle(); step(2);
    chk("t6_saturated", int'(sc_ls3), 15);
    chk("t6_cnt_ls1_b", int'(sc_ls1), 6);
    hazard(); clr_stats = 1'b1; step(1); idle(); #1;
    chk("t6_clr_wins", int'(sc_ls3), 0);
    chk("t6_clr_ls1", int'(sc_ls1), 0);
    chk("t6_still_stalling", int'(nop_o[1]), 1);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
